// File: rtl/seq_tx.sv
// seq_tx: serial frame transmitter, sends header, four payload bytes and an additive checksum MSB first.
module seq_tx #(
    parameter int unsigned        HEAD_W   = 8,
    parameter logic [HEAD_W-1:0]  HEAD     = 8'hD3,
    parameter int unsigned        GAP      = 2,
    parameter logic               IDLE_BIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] in_data0,
    input  logic [7:0] in_data1,
    input  logic [7:0] in_data2,
    input  logic [7:0] in_data3,
    input  logic       err_inj,
    output logic       data_out,
    output logic       ready,
    output logic       busy,
    output logic       frame_done
);
    localparam int unsigned FW = HEAD_W + 40;
    localparam logic [5:0] HEAD_LAST  = 6'(HEAD_W - 1);
    localparam logic [5:0] FRAME_LAST = 6'(FW - 1);
    localparam logic [5:0] PRE_LAST   = 6'(FW - 2);
    localparam logic [5:0] GAP_LAST   = 6'(GAP - 1);
    typedef enum logic [1:0] {S_IDLE, S_HEAD, S_PAYLOAD, S_GAP} state_t;
    state_t        state_q;
    logic [5:0]    cnt_q;
    logic [FW-1:0] sr_q;
    logic [FW-1:0] frame_d;
    logic [7:0]    chk_d;
    logic          data_out_q, ready_q, frame_done_q;
    always_comb begin
        chk_d   = (in_data0 + in_data1 + in_data2 + in_data3) ^ {7'd0, err_inj};
        frame_d = {HEAD, in_data0, in_data1, in_data2, in_data3, chk_d};
    end
    // The whole frame, header included, lives in one shift register; cnt_q indexes the bit on the wire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            sr_q         <= '0;
            data_out_q   <= IDLE_BIT;
            ready_q      <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    state_q    <= S_HEAD;
                    data_out_q <= frame_d[FW-1];
                    sr_q       <= frame_d << 1;
                    cnt_q      <= '0;
                    ready_q    <= 1'b0;
                end
                S_HEAD: begin
                    data_out_q <= sr_q[FW-1];
                    sr_q       <= sr_q << 1;
                    cnt_q      <= cnt_q + 6'd1;
                    if (cnt_q == HEAD_LAST) state_q <= S_PAYLOAD;
                end
                S_PAYLOAD: if (cnt_q == FRAME_LAST) begin
                    state_q      <= S_GAP;
                    data_out_q   <= IDLE_BIT;
                    frame_done_q <= 1'b0;
                    cnt_q        <= '0;
                end else begin
                    data_out_q   <= sr_q[FW-1];
                    sr_q         <= sr_q << 1;
                    cnt_q        <= cnt_q + 6'd1;
                    frame_done_q <= (cnt_q == PRE_LAST);
                end
                S_GAP: if (cnt_q == GAP_LAST) begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 6'd1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
    assign data_out   = data_out_q;
    assign ready      = ready_q;
    assign busy       = ~ready_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_seq_tx.sv
// tb_seq_tx: scoreboard bench for seq_tx; expected frames queued at stimulus, compared against captured frames.
module tb_seq_tx;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, err_inj = 1'b0;
    logic [7:0] in_data0 = '0, in_data1 = '0, in_data2 = '0, in_data3 = '0;
    logic data_out, ready, busy, frame_done;
    int checks = 0, errors = 0, cyc = 0, stray_fd = 0;
    typedef struct { logic [47:0] bits; logic [47:0] fd; int t0; } frame_t;
    frame_t got_q[$];
    logic [47:0] exp_q[$];
    logic cap = 1'b0, prev_busy = 1'b0;
    logic [47:0] cur_bits, cur_fd;
    int nb = 0, t0 = 0;

    seq_tx dut (.clk(clk), .rst_n(rst_n), .start(start), .in_data0(in_data0), .in_data1(in_data1),
                .in_data2(in_data2), .in_data3(in_data3), .err_inj(err_inj), .data_out(data_out),
                .ready(ready), .busy(busy), .frame_done(frame_done));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (time %0t, required finish)", $time);
        $fatal(1, "watchdog");
    end

    // Frame capture: starts on a busy rising edge, collects 48 bits and the frame_done pattern.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            cap = 1'b0; prev_busy = 1'b0; nb = 0;
        end else begin
            if (frame_done && !cap) stray_fd++;
            if (busy && !prev_busy) begin cap = 1'b1; nb = 0; t0 = cyc; end
            if (cap) begin
                cur_bits = {cur_bits[46:0], data_out};
                cur_fd   = {cur_fd[46:0], frame_done};
                nb++;
                if (nb == 48) begin got_q.push_back('{cur_bits, cur_fd, t0}); cap = 1'b0; end
            end
            prev_busy = busy;
        end
    end

    function automatic logic [47:0] model(input logic [7:0] a, b, c, d, input logic inj);
        int s;
        logic [7:0] k;
        s = int'(a) + int'(b) + int'(c) + int'(d);
        k = 8'(s % 256) ^ {7'd0, inj};
        return {8'hD3, a, b, c, d, k};
    endfunction

    task automatic start_frame(input logic [7:0] a, b, c, d, input logic inj);
        @(negedge clk);
        in_data0 = a; in_data1 = b; in_data2 = c; in_data3 = d; err_inj = inj; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_q.push_back(model(a, b, c, d, inj));
    endtask

    task automatic wait_frames(input int n);
        for (int i = 0; i < 300 && got_q.size() < n; i++) begin @(negedge clk); #1; end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (data_out !== 1'b0 || ready !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
            errors++; $display("FAIL reset_hold: dout/ready/busy/fd=%b%b%b%b required 0100", data_out, ready, busy, frame_done);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (data_out !== 1'b0 || ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_release: dout/ready/busy=%b%b%b required 010", data_out, ready, busy);
        end
    endtask

    task automatic test_nominal;
        frame_t g;
        logic [47:0] e;
        start_frame(8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
        wait_frames(1);
        checks++; if (got_q.size() == 0) begin errors++; $display("FAIL nominal_timeout: no frame, required 1"); end
        else begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g.bits !== e) begin errors++; $display("FAIL nominal_bits: got %h required %h", g.bits, e); end
            checks++; if (g.bits !== 48'hD312345678_14) begin errors++; $display("FAIL nominal_const: got %h required d31234567814", g.bits); end
            checks++; if (g.fd !== 48'h1) begin errors++; $display("FAIL nominal_frame_done: got %h required 000000000001", g.fd); end
            checks++; if (g.bits[39:8] !== 32'h12345678 || g.bits[47:40] !== 8'hD3) begin
                errors++; $display("FAIL nominal_decode: hdr %h data %h required d3 12345678", g.bits[47:40], g.bits[39:8]);
            end
            checks++; if (8'(g.bits[39:32] + g.bits[31:24] + g.bits[23:16] + g.bits[15:8]) !== g.bits[7:0]) begin
                errors++; $display("FAIL nominal_rx_check: chk %h not valid, required valid", g.bits[7:0]);
            end
            for (int i = 0; i < 2; i++) begin
                @(negedge clk); #1;
                checks++; if (ready !== 1'b0 || data_out !== 1'b0) begin
                    errors++; $display("FAIL nominal_gap%0d: ready/dout=%b%b required 00", i, ready, data_out);
                end
            end
            @(negedge clk); #1;
            checks++; if (ready !== 1'b1) begin errors++; $display("FAIL nominal_ready_back: ready=%b required 1", ready); end
        end
    endtask

    task automatic test_checksum_wrap;
        frame_t g;
        logic [47:0] e;
        logic [7:0] req [2] = '{8'hFC, 8'h00};
        for (int t = 0; t < 2; t++) begin
            if (t == 0) start_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0);
            else        start_frame(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
            wait_frames(1);
            checks++; if (got_q.size() == 0) begin errors++; $display("FAIL wrap%0d_timeout: no frame, required 1", t); end
            else begin
                g = got_q.pop_front(); e = exp_q.pop_front();
                checks++; if (g.bits !== e) begin errors++; $display("FAIL wrap%0d_bits: got %h required %h", t, g.bits, e); end
                checks++; if (g.bits[7:0] !== req[t]) begin errors++; $display("FAIL wrap%0d_chk: got %h required %h", t, g.bits[7:0], req[t]); end
            end
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_err_inj;
        frame_t g;
        logic [47:0] e;
        start_frame(8'h12, 8'h34, 8'h56, 8'h78, 1'b1);
        wait_frames(1);
        checks++; if (got_q.size() == 0) begin errors++; $display("FAIL errinj_timeout: no frame, required 1"); end
        else begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g.bits !== e) begin errors++; $display("FAIL errinj_bits: got %h required %h", g.bits, e); end
            checks++; if (g.bits[7:0] !== 8'h15) begin errors++; $display("FAIL errinj_chk: got %h required 15", g.bits[7:0]); end
            checks++; if (8'(g.bits[39:32] + g.bits[31:24] + g.bits[23:16] + g.bits[15:8]) === g.bits[7:0]) begin
                errors++; $display("FAIL errinj_rx_check: check flag 1 required 0");
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_busy_reject;
        frame_t g;
        logic [47:0] e;
        start_frame(8'h01, 8'h23, 8'h45, 8'h67, 1'b0);
        repeat (20) @(negedge clk);
        in_data0 = 8'hAA; in_data1 = 8'hAA; in_data2 = 8'hAA; in_data3 = 8'hAA; err_inj = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_frames(1);
        checks++; if (got_q.size() == 0) begin errors++; $display("FAIL reject_timeout: no frame, required 1"); end
        else begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g.bits !== e) begin errors++; $display("FAIL reject_bits: got %h required %h", g.bits, e); end
        end
        repeat (120) @(negedge clk);
        #1;
        checks++; if (got_q.size() != 0 || ready !== 1'b1) begin
            errors++; $display("FAIL reject_no_second: frames %0d ready %b required 0 1", got_q.size(), ready);
        end
        err_inj = 1'b0;
    endtask

    task automatic test_back_to_back;
        frame_t g [3];
        logic [47:0] e;
        @(negedge clk);
        in_data0 = 8'h9C; in_data1 = 8'h3E; in_data2 = 8'hF0; in_data3 = 8'h81; err_inj = 1'b0; start = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(model(8'h9C, 8'h3E, 8'hF0, 8'h81, 1'b0));
        wait_frames(3);
        start = 1'b0;
        checks++; if (got_q.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d frames required 3", got_q.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                g[i] = got_q.pop_front(); e = exp_q.pop_front();
                checks++; if (g[i].bits !== e) begin errors++; $display("FAIL b2b_bits%0d: got %h required %h", i, g[i].bits, e); end
            end
            for (int i = 1; i < 3; i++) begin
                checks++; if (g[i].t0 - g[i-1].t0 != 51) begin
                    errors++; $display("FAIL b2b_period%0d: got %0d required 51", i, g[i].t0 - g[i-1].t0);
                end
            end
        end
        exp_q.delete();
        repeat (10) @(negedge clk);
        #1;
        checks++; if (ready !== 1'b1 || got_q.size() != 0) begin
            errors++; $display("FAIL b2b_stop: ready %b extra frames %0d required 1 0", ready, got_q.size());
        end
    endtask

    task automatic test_reset_mid;
        frame_t g;
        logic [47:0] e;
        start_frame(8'h5A, 8'hC3, 8'h0F, 8'hE1, 1'b0);
        repeat (28) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (data_out !== 1'b0 || ready !== 1'b1 || frame_done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_outputs: dout/ready/fd/busy=%b%b%b%b required 0100", data_out, ready, frame_done, busy);
        end
        void'(exp_q.pop_front());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (got_q.size() != 0 || data_out !== 1'b0) begin
            errors++; $display("FAIL rstmid_abort: frames %0d dout %b required 0 0", got_q.size(), data_out);
        end
        start_frame(8'h77, 8'h88, 8'h99, 8'hAB, 1'b0);
        wait_frames(1);
        checks++; if (got_q.size() == 0) begin errors++; $display("FAIL rstmid_timeout: no frame, required 1"); end
        else begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g.bits !== e) begin errors++; $display("FAIL rstmid_bits: got %h required %h", g.bits, e); end
            checks++; if (g.fd !== 48'h1) begin errors++; $display("FAIL rstmid_fd: got %h required 000000000001", g.fd); end
        end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_checksum_wrap();
        test_err_inj();
        test_busy_reject();
        test_back_to_back();
        test_reset_mid();
        checks++; if (stray_fd != 0) begin errors++; $display("FAIL stray_frame_done: got %0d required 0", stray_fd); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
